// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ execution units.
// Grants are combinational; the granted write is registered onto the reg_file port.
module rf_write_arbiter #(
  parameter int unsigned NREQ = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic [(1<<AW)-1:0]    pend_mask,
  output logic [2:0]            grant_idx
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 1 << AW;

  logic [PW-1:0] ptr;
  logic [PW:0]   scan_idx;
  logic          gnt_found_c;
  logic [PW-1:0] gnt_sel_c;
  logic [NREQ-1:0] ready_c;

  // Scan from ptr upward (mod NREQ); first valid requester wins. Data never feeds this path.
  always_comb begin
    ready_c     = '0;
    gnt_found_c = 1'b0;
    gnt_sel_c   = '0;
    scan_idx    = '0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = {1'b0, ptr} + (PW+1)'(k);
        if (scan_idx >= (PW+1)'(NREQ))
          scan_idx = scan_idx - (PW+1)'(NREQ);
        if (!gnt_found_c && req_valid[scan_idx[PW-1:0]]) begin
          gnt_found_c = 1'b1;
          gnt_sel_c   = scan_idx[PW-1:0];
        end
      end
      if (gnt_found_c)
        ready_c[gnt_sel_c] = 1'b1;
    end
  end

  assign req_ready = ready_c;

  // Pointer and write-port register; an in-flight write is discarded by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_idx <= '0;
    end else if (gnt_found_c) begin
      ptr       <= (gnt_sel_c == PW'(NREQ-1)) ? '0 : gnt_sel_c + PW'(1);
      wr_en     <= 1'b1;
      wr_addr   <= req_addr[gnt_sel_c*AW +: AW];
      wr_data   <= req_data[gnt_sel_c*DW +: DW];
      grant_idx <= 3'(gnt_sel_c);
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Registers with a write either still requested or sitting on the write port.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i])
        pend_mask[req_addr[i*AW +: AW]] = 1'b1;
    end
    if (wr_en)
      pend_mask[wr_addr] = 1'b1;
  end

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, round-robin, fairness, hold, races.
module tb_rf_write_arbiter;

  localparam int unsigned NREQ = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [31:0]       pend_mask;
  logic [2:0]        grant_idx;

  int compared   = 0;
  int mismatched = 0;

  rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_mask(pend_mask), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [2:0] g);
    chk({tag, "_en"},   32'(wr_en),     32'(en));
    chk({tag, "_addr"}, 32'(wr_addr),   32'(a));
    chk({tag, "_data"}, 32'(wr_data),   32'(d));
    chk({tag, "_gidx"}, 32'(grant_idx), 32'(g));
  endtask

  initial begin
    reset     = 1'b0;
    hold      = 1'b1;
    req_valid = 5'b11111;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'(32'h100 + i));

    // 1: reset state, grants blocked only by hold
    #3;
    chk("rst_ready_hold", 32'(req_ready), 32'(5'b00000));
    chk_wr("rst", 1'b0, 5'd0, 32'h0, 3'd0);
    tick();
    chk("rst_wr_en_clk", 32'(wr_en), 32'd0);
    hold = 1'b0;
    #1;
    chk("rst_ready_nohold", 32'(req_ready), 32'(5'b00001));
    req_valid = '0;
    #1;
    chk("rst_idle_ready", 32'(req_ready), 32'(5'b00000));
    chk("rst_idle_pend", pend_mask, 32'h0);
    tick();
    reset = 1'b1;
    req_valid = 5'b11111;
    #1;
    chk("rel_ready_first", 32'(req_ready), 32'(5'b00001));
    req_valid = '0;

    // 2: single alu request
    tick();
    set_req(0, 5'd3, 32'h12345678);
    req_valid = 5'b00001;
    #1;
    chk("single_ready", 32'(req_ready), 32'(5'b00001));
    chk("single_pend_req", pend_mask, 32'h8);
    tick();
    chk_wr("single_wr", 1'b1, 5'd3, 32'h12345678, 3'd0);
    req_valid = '0;
    #1;
    chk("single_pend_flight", pend_mask, 32'h8);
    tick();
    chk("single_wr_en_drop", 32'(wr_en), 32'd0);
    chk("single_pend_clear", pend_mask, 32'h0);

    // 3: round robin from ptr=0, all valid continuously
    pulse_reset();
    set_req(0, 5'd10, 32'h100);
    req_valid = 5'b11111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = n % NREQ;
      #1;
      chk($sformatf("rr_ready_%0d", n), 32'(req_ready), 32'(1) << e);
      tick();
      chk_wr($sformatf("rr_wr_%0d", n), 1'b1, AW'(10 + e), DW'(32'h100 + e), 3'(e));
    end
    req_valid = '0;

    // 4: fairness with ptr=2 (grant 1 alone first to move ptr from 1 to 2)
    req_valid = 5'b00010;
    tick();
    req_valid = 5'b10010;
    #1;
    chk("fair_ready_first", 32'(req_ready), 32'(5'b10000));
    tick();
    chk("fair_gidx_first", 32'(grant_idx), 32'd4);
    req_valid = 5'b00010;
    #1;
    chk("fair_ready_second", 32'(req_ready), 32'(5'b00010));
    tick();
    chk("fair_gidx_second", 32'(grant_idx), 32'd1);
    req_valid = 5'b11111;
    #1;
    chk("fair_ptr_end", 32'(req_ready), 32'(5'b00100));

    // 5: hold with requester 2 valid; pending write still completes
    req_valid = 5'b00100;
    hold = 1'b1;
    #1;
    chk("hold_ready0", 32'(req_ready), 32'(5'b00000));
    chk("hold_inflight", 32'(wr_en), 32'd1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("hold_wr_en_%0d", n), 32'(wr_en), 32'd0);
      chk($sformatf("hold_ready_%0d", n), 32'(req_ready), 32'(5'b00000));
      chk($sformatf("hold_gidx_%0d", n), 32'(grant_idx), 32'd1);
    end
    hold = 1'b0;
    #1;
    chk("hold_release_ready", 32'(req_ready), 32'(5'b00100));
    tick();
    chk_wr("hold_release_wr", 1'b1, 5'd12, 32'h102, 3'd2);
    req_valid = '0;

    // 6: same-address race from ptr=0, then async reset during a write
    tick();
    pulse_reset();
    set_req(1, 5'd7, 32'hA);
    set_req(4, 5'd7, 32'hB);
    req_valid = 5'b10010;
    #1;
    chk("race_ready_first", 32'(req_ready), 32'(5'b00010));
    chk("race_pend_req", pend_mask, 32'h80);
    tick();
    chk_wr("race_wr_a", 1'b1, 5'd7, 32'hA, 3'd1);
    req_valid = 5'b10000;
    #1;
    chk("race_ready_second", 32'(req_ready), 32'(5'b10000));
    chk("race_pend_mid", pend_mask, 32'h80);
    tick();
    chk_wr("race_wr_b", 1'b1, 5'd7, 32'hB, 3'd4);
    req_valid = '0;
    #1;
    chk("race_pend_last", pend_mask, 32'h80);
    reset = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_pend", pend_mask, 32'h0);
    reset = 1'b1;

    // register 0 is written like any other
    tick();
    set_req(0, 5'd0, 32'hDEAD0000);
    req_valid = 5'b00001;
    #1;
    chk("r0_pend", pend_mask, 32'h1);
    tick();
    chk_wr("r0_wr", 1'b1, 5'd0, 32'hDEAD0000, 3'd0);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
